// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks up to NUM_PORTS functional-unit results per cycle
// and packs them onto the ROB finish ports. Requesters that have waited too
// long are promoted ahead of the round-robin order.

// Per-requester wait counter and starvation flag.
module wb_wait_ctr #(
  parameter int LIMIT = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic valid,
  input  logic grant,
  output logic starved
);

  logic [3:0] cnt, cnt_nxt;

  // Count cycles spent valid but not granted; saturate at 15.
  always_comb begin
    cnt_nxt = cnt;
    if (!valid || grant)    cnt_nxt = '0;
    else if (cnt != 4'hF)   cnt_nxt = cnt + 4'd1;
  end

  // Counter and flag registers; the flag tracks the counter's next value so
  // it always equals (cnt >= LIMIT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      starved <= 1'b0;
    end else if (flush) begin
      cnt     <= '0;
      starved <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      starved <= (cnt_nxt >= 4'(LIMIT));
    end
  end

endmodule

module wb_arbiter #(
  parameter int NUM_REQ      = 6,
  parameter int NUM_PORTS    = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*4-1:0]   req_index,
  input  logic [NUM_REQ*16-1:0]  req_value,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             rob_num_finished,
  output logic [NUM_PORTS*4-1:0] rob_indices,
  output logic [NUM_PORTS*16-1:0] rob_values,
  output logic [NUM_REQ-1:0]     starved
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_REQ-1:0][3:0]    idx_a;
  logic [NUM_REQ-1:0][15:0]   val_a;
  logic [PW-1:0]              rr_ptr, rr_nxt, r_c;
  logic [NUM_REQ-1:0]         grant;
  logic [2:0]                 n_g, q_num;
  logic [NUM_PORTS-1:0][3:0]  p_idx, q_idx;
  logic [NUM_PORTS-1:0][15:0] p_val, q_val;

  assign idx_a = req_index;
  assign val_a = req_value;

  // (b + i) mod NUM_REQ for b < NUM_REQ and i <= NUM_REQ.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] b, input int i);
    logic [PW:0] s;
    s = {1'b0, b} + (PW+1)'(i);
    if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
    return s[PW-1:0];
  endfunction

  // Two rotating scans from rr_ptr: promoted requesters first, then the rest.
  // Ports fill in grant order; the pointer lands just past the last grant.
  always_comb begin
    grant  = '0;
    n_g    = '0;
    p_idx  = '0;
    p_val  = '0;
    rr_nxt = rr_ptr;
    r_c    = '0;
    if (rst_n && !flush) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          r_c = rot(rr_ptr, i);
          if (req_valid[r_c] && (starved[r_c] == (p == 0)) &&
              (n_g < 3'(NUM_PORTS))) begin
            grant[r_c]          = 1'b1;
            p_idx[n_g[CW-1:0]]  = idx_a[r_c];
            p_val[n_g[CW-1:0]]  = val_a[r_c];
            n_g                 = n_g + 3'd1;
            rr_nxt              = rot(r_c, 1);
          end
        end
      end
    end
  end

  assign req_ready = grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
    wb_wait_ctr #(.LIMIT(STARVE_LIMIT)) u_wait (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .valid   (req_valid[g]),
      .grant   (grant[g]),
      .starved (starved[g])
    );
  end

  // Finish-port registers and rotation pointer; flush wipes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_num  <= '0;
      q_idx  <= '0;
      q_val  <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      q_num  <= '0;
      q_idx  <= '0;
      q_val  <= '0;
      rr_ptr <= '0;
    end else begin
      q_num <= n_g;
      q_idx <= p_idx;
      q_val <= p_val;
      if (|grant) rr_ptr <= rr_nxt;
    end
  end

  assign rob_num_finished = q_num;
  assign rob_indices      = q_idx;
  assign rob_values       = q_val;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6: number of functional-unit writeback requesters (legal range 2..8).
REQ-002 Parameter NUM_PORTS, default 4: number of ROB finish ports driven per cycle (fixed at 4 for the current ROB).
REQ-003 Parameter STARVE_LIMIT, default 7: number of consecutive waiting cycles after which a requester is promoted (legal range 1..15).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 req_valid  input  NUM_REQ  per-requester result-valid flag.
REQ-008 req_index  input  NUM_REQ*4  per-requester ROB entry index; requester r occupies bits [4r+3:4r].
REQ-009 req_value  input  NUM_REQ*16  per-requester result value; requester r occupies bits [16r+15:16r].
REQ-010 req_ready  output  NUM_REQ  per-requester grant; combinational from the current state and inputs.
REQ-011 rob_num_finished  output  3  count of valid ROB finish ports this cycle (0..4); registered.
REQ-012 rob_indices  output  NUM_PORTS*4  ROB entry index per port, packed from port 0; registered.
REQ-013 rob_values  output  NUM_PORTS*16  result value per port, packed from port 0; registered.
REQ-014 starved  output  NUM_REQ  per-requester starvation-promotion flag; registered.

Function
REQ-015 A transfer on requester r SHALL occur in a cycle where req_valid[r] and req_ready[r] are both 1; a requester holding valid SHALL keep its index and value stable until that transfer.
REQ-016 req_ready[r] SHALL be 0 whenever req_valid[r] is 0 or flush is 1.
REQ-017 At most NUM_PORTS requesters SHALL be granted per cycle.
REQ-018 Grant order: first, starved valid requesters are scanned from rr_ptr upward, modulo NUM_REQ; second, non-starved valid requesters are scanned with the same rotation; granting stops when 4 requesters are selected.
REQ-019 Granted requesters SHALL be placed on ROB ports 0,1,2,... in grant order, and the port contents SHALL appear at the outputs on the next posedge (latency 1 cycle).
REQ-020 Unused ports (port number >= rob_num_finished) SHALL drive index 0 and value 0.
REQ-021 rr_ptr (internal, range 0..NUM_REQ-1) SHALL update to (last granted requester + 1) mod NUM_REQ when at least one requester is granted, and SHALL hold otherwise.
REQ-022 Each requester SHALL have a 4-bit wait counter:
  - incremented (saturating at 15) when valid and not granted;
  - cleared on grant or when valid is low.
REQ-023 starved[r] SHALL be 1 while wait counter r >= STARVE_LIMIT.
REQ-024 When flush is 1 at a posedge, the block SHALL:
  - set rob_num_finished, indices and values to 0 at the next output;
  - reset rr_ptr to 0;
  - clear all wait counters and starved flags.
REQ-025 Flush SHALL take priority over all other updates in the same cycle.
REQ-026 The block SHALL NOT check for duplicate req_index values; ensuring they are unique is the requesters' responsibility.
REQ-027 rob_num_finished SHALL be computed with 3-bit width, and all rotation arithmetic SHALL wrap modulo NUM_REQ.

Reset
REQ-028 On rst_n low, the block SHALL immediately set, independent of clk:
  - rob_num_finished, rob_indices, rob_values, starved and rr_ptr to 0;
  - all wait counters to 0.
REQ-029 While rst_n is low, req_ready SHALL be all 0.
REQ-030 State SHALL first update at the first posedge after rst_n rises.
REQ-031 Reset asserted mid-transfer SHALL discard any pending port contents; no partial output SHALL survive.

Verification
REQ-032 Single request: req_valid=6'b000100, index=5, value=16'hBEEF -> req_ready=6'b000100; next cycle rob_num_finished=1, port0 = (5, 16'hBEEF); rr_ptr=3.
REQ-033 All six valid with rr_ptr=0:
  - cycle 1 -> requesters 0-3 granted; next cycle num_finished=4 with ports in order 0,1,2,3; rr_ptr=4.
  - cycle 2, all six held valid -> requesters 4,5,0,1 granted.
REQ-034 Starvation:
  - hold requester 5 valid while requesters 0-4 are repeatedly granted ahead of it -> starved[5]=1 once its counter reaches 7;
  - on the next grant cycle, requester 5 is selected first and appears on port 0.
REQ-035 Flush: with 4 valid requests, flush=1 -> req_ready=0; next cycle rob_num_finished=0, all ports 0, rr_ptr=0, starved=0.
REQ-036 Reset mid-operation: drop rst_n asynchronously while rob_num_finished=3 -> outputs are 0 before the next posedge; after release with no requests, outputs stay 0.
